// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit arbiter.
//   UART_DATA_W : width of one UART character.
//   state_t     : controller states (3-bit encoding).
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,  // unlocked, looking for a new owner
    S_HOLD  = 3'd1,  // locked, waiting for the owner's next byte
    S_ISSUE = 3'd2,  // start strobe to the UART
    S_ACK   = 3'd3,  // waiting for the UART to raise busy
    S_DRAIN = 3'd4   // waiting for the UART to finish the byte
  } state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker.
// Returns the first set bit of req at or above ptr, wrapping to bit 0
// when nothing at or above ptr is set.
// Ports:
//   req  : request vector (one bit per requester)
//   ptr  : index with highest priority this cycle
//   pick : one-hot winner (all zero when req is zero)
//   any  : at least one request is present
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               any
);

  logic [NUM_REQ-1:0] at_or_above;
  logic [NUM_REQ-1:0] upper;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign at_or_above[gi] = (PTR_W'(gi) >= ptr);
    end
  endgenerate

  assign upper = req & at_or_above;

  // x & -x isolates the lowest set bit. Requests at or above the pointer
  // win; otherwise the search wraps and the lowest request overall wins.
  assign pick = (|upper) ? (upper & (-upper)) : (req & (-req));
  assign any  = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8-bit UART transmitter between NUM_REQ
// byte-stream requesters. Round-robin arbitration, grant locked for a
// whole message (ended by req_last), one byte at a time through the
// UART enable/busy handshake.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   req_valid[i] : requester i offers a byte
//   req_data     : byte of requester i at [8i+7:8i]
//   req_last[i]  : the offered byte ends requester i's message
//   req_ready[i] : byte of requester i accepted this cycle (with valid)
//   grant        : one-hot lock owner, zero when unlocked
//   uart_enablen : active-low one-cycle start strobe to the UART
//   uart_data    : registered byte presented to the UART
//   uart_busy    : UART busy flag
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         uart_enablen,
  output logic [UART_DATA_W-1:0]       uart_data,
  input  logic                         uart_busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // The lock is dropped in the cycle whose increment would bring the
  // counter to LOCK_TIMEOUT, so the owner gets exactly LOCK_TIMEOUT
  // idle cycles in S_HOLD.
  localparam logic [CNT_W-1:0] CNT_LAST =
    (LOCK_TIMEOUT > 0) ? CNT_W'(LOCK_TIMEOUT - 1) : '0;

  state_t                 state_reg, state_next;
  logic [NUM_REQ-1:0]     grant_reg, grant_next;
  logic [PTR_W-1:0]       owner_reg, owner_next;
  logic [PTR_W-1:0]       ptr_reg, ptr_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [UART_DATA_W-1:0] data_reg, data_next;
  logic                   last_reg, last_next;

  logic [NUM_REQ-1:0]     pick;
  logic                   pick_any;
  logic [PTR_W-1:0]       pick_idx;
  logic [PTR_W-1:0]       sel_idx;
  logic [PTR_W-1:0]       owner_inc;
  logic                   owner_valid;
  logic [UART_DATA_W-1:0] data_arr [NUM_REQ];

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req  (req_valid),
    .ptr  (ptr_reg),
    .pick (pick),
    .any  (pick_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign data_arr[gi] = req_data[UART_DATA_W*gi +: UART_DATA_W];
    end
  endgenerate

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

  // In S_IDLE the byte comes from the picked requester, otherwise from
  // the lock owner.
  assign sel_idx     = (state_reg == S_IDLE) ? pick_idx : owner_reg;
  assign owner_inc   = (owner_reg == PTR_W'(NUM_REQ - 1)) ? '0
                                                          : owner_reg + PTR_W'(1);
  assign owner_valid = |(req_valid & grant_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      grant_reg <= '0;
      owner_reg <= '0;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    owner_next   = owner_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    data_next    = data_reg;
    last_next    = last_reg;
    req_ready    = '0;
    uart_enablen = 1'b1;

    case (state_reg)
      S_IDLE: begin
        // pick only contains valid requesters, so ready implies accept.
        if (pick_any && !uart_busy) begin
          req_ready  = pick;
          data_next  = data_arr[sel_idx];
          last_next  = req_last[sel_idx];
          grant_next = pick;
          owner_next = pick_idx;
          cnt_next   = '0;
          state_next = S_ISSUE;
        end
      end

      S_HOLD: begin
        if (!uart_busy) req_ready = grant_reg;
        if (owner_valid && !uart_busy) begin
          // An accept beats a timeout expiring in the same cycle.
          data_next  = data_arr[sel_idx];
          last_next  = req_last[sel_idx];
          cnt_next   = '0;
          state_next = S_ISSUE;
        end else if (!owner_valid) begin
          if (LOCK_TIMEOUT != 0 && cnt_reg == CNT_LAST) begin
            grant_next = '0;
            ptr_next   = owner_inc;
            cnt_next   = '0;
            state_next = S_IDLE;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      S_ISSUE: begin
        uart_enablen = 1'b0;
        state_next   = S_ACK;
      end

      S_ACK: begin
        if (uart_busy) state_next = S_DRAIN;
      end

      S_DRAIN: begin
        if (!uart_busy) begin
          if (last_reg) begin
            grant_next = '0;
            ptr_next   = owner_inc;
            state_next = S_IDLE;
          end else begin
            state_next = S_HOLD;
          end
        end
      end

      default: begin
        grant_next = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  assign grant     = grant_reg;
  assign uart_data = data_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues feed the DUT,
// expected {grant, byte} pairs are queued in hand-computed service order,
// and a monitor compares every UART start strobe against the queue head.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int TO       = 8;
  localparam int BUSY_LEN = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     grant;
  logic             uart_enablen;
  logic [7:0]       uart_data;
  logic             uart_busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [8:0]       rq [N][$];
  logic [N+7:0]     sb [$];
  logic [N-1:0]     hs = '0;
  int               busy_cnt = 0;
  logic             prev_en = 1'b1;
  logic [N+7:0]     exp_e;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .LOCK_TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .grant        (grant),
    .uart_enablen (uart_enablen),
    .uart_data    (uart_data),
    .uart_busy    (uart_busy)
  );

  // UART model: busy from two cycles after the accept for BUSY_LEN cycles.
  assign uart_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    hs <= req_valid & req_ready;
    if (!uart_enablen) busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // Requester driver: presents queue heads, pops on handshake.
  initial begin
    logic [8:0] head;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      for (int i = 0; i < N; i++) begin
        if (rq[i].size() > 0) begin
          head              = rq[i][0];
          req_valid[i]      = 1'b1;
          req_data[8*i +: 8] = head[7:0];
          req_last[i]       = head[8];
        end else begin
          req_valid[i]      = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]       = 1'b0;
        end
      end
    end
  end

  // Monitor: every start strobe must match the scoreboard head, be one
  // cycle long and follow the accepting handshake by one cycle.
  always @(negedge clk) begin
    if (!uart_enablen) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL strobe: unexpected byte %02h grant %b", uart_data, grant);
      end else begin
        exp_e = sb.pop_front();
        if (uart_data !== exp_e[7:0] || grant !== exp_e[N+7:8] ||
            hs !== exp_e[N+7:8] || !prev_en) begin
          miscompares++;
          $display("FAIL strobe: got data %02h grant %b accept %b prev_en %b, expected data %02h grant %b accept %b prev_en 1",
                   uart_data, grant, hs, prev_en, exp_e[7:0], exp_e[N+7:8], exp_e[N+7:8]);
        end else begin
          $display("strobe ok: data %02h grant %b", uart_data, grant);
        end
      end
    end
    prev_en = uart_enablen;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(int i, logic [7:0] d, logic last);
    rq[i].push_back({last, d});
  endtask

  task automatic expect_byte(int i, logic [7:0] d);
    logic [N-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    sb.push_back({oh, d});
  endtask

  function automatic bit all_idle();
    bit ok;
    ok = (sb.size() == 0) && (grant == '0) && !uart_busy;
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) ok = 1'b0;
    return ok;
  endfunction

  task automatic wait_idle(string nm);
    int k;
    k = 0;
    while (k < 400 && !all_idle()) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (!all_idle()) begin
      miscompares++;
      $display("FAIL %s: not idle after %0d cycles, grant %b pending %0d", nm, k, grant, sb.size());
    end
    @(negedge clk);
  endtask

  task automatic wait_grant(logic [N-1:0] g, string nm);
    int k;
    k = 0;
    while (k < 200 && grant !== g) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(grant), 32'(g));
  endtask

  initial begin
    int k;
    int hold;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_enablen", 32'(uart_enablen), 32'h1);
    chk("reset_data", 32'(uart_data), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Contention from pointer 0: 0,1,2; pointer ends at 3.
    send(0, 8'h10, 1'b1); send(1, 8'h11, 1'b1); send(2, 8'h12, 1'b1);
    expect_byte(0, 8'h10); expect_byte(1, 8'h11); expect_byte(2, 8'h12);
    wait_idle("contention_a");
    // Pointer 3, requesters 0 and 2: wrap to 0, then 2.
    send(0, 8'h20, 1'b1); send(2, 8'h22, 1'b1);
    expect_byte(0, 8'h20); expect_byte(2, 8'h22);
    wait_idle("contention_b");

    // Single byte message; lock released afterwards, pointer becomes 1.
    send(0, 8'h41, 1'b1);
    expect_byte(0, 8'h41);
    wait_grant(4'b0001, "single_grant");
    wait_idle("single");
    chk("single_release", 32'(grant), 32'h0);
    chk("single_data_held", 32'(uart_data), 32'h41);

    // Message lock: "abc" from requester 1 while requester 0 waits.
    send(1, 8'h61, 1'b0); send(1, 8'h62, 1'b0); send(1, 8'h63, 1'b1);
    send(0, 8'h30, 1'b1);
    expect_byte(1, 8'h61); expect_byte(1, 8'h62); expect_byte(1, 8'h63);
    expect_byte(0, 8'h30);
    wait_grant(4'b0010, "lock_grant");
    k = 0;
    while (k < 300 && grant === 4'b0010) begin
      chk("lock_ready0", 32'(req_ready[0]), 32'h0);
      @(negedge clk);
      k++;
    end
    wait_idle("lock");

    // Timeout: requester 2 stalls mid-message, requester 3 takes over.
    send(2, 8'h55, 1'b0); send(3, 8'h33, 1'b1);
    expect_byte(2, 8'h55); expect_byte(3, 8'h33);
    wait_grant(4'b0100, "timeout_grant");
    hold = 0;
    k = 0;
    while (k < 200 && grant === 4'b0100) begin
      if (req_ready[2]) hold++;
      @(negedge clk);
      k++;
    end
    chk("timeout_hold_cycles", 32'(hold), 32'(TO));
    wait_idle("timeout");

    // Wrap-around: move pointer to 3, then requesters 0 and 3 compete.
    send(2, 8'h02, 1'b1);
    expect_byte(2, 8'h02);
    wait_idle("wrap_setup");
    send(0, 8'h40, 1'b1); send(3, 8'h43, 1'b1);
    expect_byte(3, 8'h43); expect_byte(0, 8'h40);
    wait_idle("wrap");

    // Reset while draining the first byte of a two-byte message.
    send(1, 8'h58, 1'b0); send(1, 8'h59, 1'b1);
    expect_byte(1, 8'h58);
    k = 0;
    while (k < 100 && !uart_busy) begin
      @(negedge clk);
      k++;
    end
    chk("drain_busy", 32'(uart_busy), 32'h1);
    @(negedge clk);
    send(3, 8'h5A, 1'b1);
    rst = 1'b1;
    #1;
    chk("midreset_ready", 32'(req_ready), 32'h0);
    chk("midreset_grant", 32'(grant), 32'h0);
    chk("midreset_enablen", 32'(uart_enablen), 32'h1);
    chk("midreset_data", 32'(uart_data), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Fresh arbitration from pointer 0: requester 1 then 3.
    expect_byte(1, 8'h59); expect_byte(3, 8'h5A);
    wait_idle("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single 8-bit UART transmitter between NUM_REQ byte-stream requesters (CPU console, debug dumper, etc.).
- Arbitrates round-robin.
- Locks the grant for a whole message, delimited by req_last, so text from different requesters never interleaves.
- Sequences the UART's enable/busy handshake one byte at a time.
- Sits between the requesters and the uart transmitter instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
LOCK_TIMEOUT, 1023, idle cycles a locked owner may stall without req_valid before the lock is forcibly released; 0 disables the timeout.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
req_valid  in  NUM_REQ  requester i has a byte on its req_data slice.
req_data  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i].
req_last  in  NUM_REQ  byte for requester i ends its message.
req_ready  out  NUM_REQ  byte for requester i is accepted this cycle when req_valid[i] is also 1.
grant  out  NUM_REQ  one-hot current lock owner; all zero when unlocked.
uart_enablen  out  1  active-low one-cycle start strobe to the UART.
uart_data  out  8  byte presented to the UART.
uart_busy  in  1  UART busy flag.

Behaviour:
- Reset values: req_ready=0, grant=0, uart_enablen=1, uart_data=0, rr pointer=0, idle counter=0, state=S_IDLE.
- Reset is asynchronous and takes effect mid-transfer. The UART is reset independently.
- States:
  - S_IDLE: unlocked. Candidate = first i with req_valid[i], searching from the pointer upward with wrap-around. req_ready[candidate]=1 (combinational) only if uart_busy=0. On accept: latch the data byte and the last bit, set grant=onehot(candidate), go to S_ISSUE.
  - S_HOLD: locked, waiting for the owner's next byte. req_ready[owner]=1 if uart_busy=0. On accept: latch, clear the idle counter, go to S_ISSUE. Each cycle without owner req_valid increments the idle counter. If LOCK_TIMEOUT!=0 and the counter reaches LOCK_TIMEOUT: release the lock (grant=0), set pointer=owner+1 mod NUM_REQ, go to S_IDLE.
  - S_ISSUE: uart_enablen=0 for exactly this cycle, go to S_ACK.
  - S_ACK: wait for uart_busy=1, then go to S_DRAIN.
  - S_DRAIN: wait for uart_busy=0. If the latched last bit is 1: release the lock, pointer=owner+1 mod NUM_REQ, go to S_IDLE. Otherwise go to S_HOLD.
- Latency: an accept in cycle T gives uart_enablen=0 in T+1 and uart_data valid from T+1.
- uart_data is a register. It changes only on accept and stays stable until the next accept.
- req_ready: at most one bit set. Never set in S_ISSUE, S_ACK or S_DRAIN.
- Non-owners are never granted while the lock is held, even if they assert valid.
- Simultaneous valids in S_IDLE are resolved strictly by the rr pointer.
- req_last=1 on a single-byte message: the lock is released after that byte drains.
- If the owner's valid and the timeout expiry fall in the same cycle, the accept wins and the counter clears.
- The pointer is not advanced in S_IDLE without an accept.
- Timeout counter width is clog2(LOCK_TIMEOUT+1). The counter saturates and never wraps.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W=8.
  - State encoding constants S_IDLE, S_HOLD, S_ISSUE, S_ACK, S_DRAIN (3-bit).
- Sub-module uart_rr_pick: combinational, inputs req vector and pointer, outputs one-hot pick and an any flag. It contains the wrap-around priority search.
- The controller FSM, data/last registers, pointer and timeout counter live in uart_tx_arbiter.

Test Plan:
1. Single byte: req_valid[0]=1, data 0x41, last=1; UART model asserts busy from T+2 to T+20 → one enablen pulse at T+1, uart_data=0x41, grant 0001 then 0000, pointer=1.
2. Contention: req 0,1,2 all valid single-byte messages, pointer=0 → service order 0,1,2; next round with req 0 and 2 valid, pointer=3 → 0 then 2.
3. Message lock: req1 sends 3 bytes "abc" (last on 'c') while req0 is continuously valid → UART sees a,b,c before any req0 byte; req_ready[0] stays 0 throughout.
4. Timeout: LOCK_TIMEOUT=8; req2 sends a byte with last=0 then drops valid; req3 is valid → grant released 8 cycles after entering S_HOLD, req3 served next.
5. Wrap-around: NUM_REQ=4, pointer=3, req 0 and 3 valid → 3 served first, pointer=0, then 0.
6. Reset mid-transfer: reset asserted in S_DRAIN → outputs immediately return to reset values, req_ready=0. After release, a pending request starts a fresh arbitration from pointer 0.
